// File: rtl/prog_launch_ctrl.sv
// Program-launch sequencer: turns Start pulses into one-cycle PC loads of each program's entry address.
// Optional watchdog (forces FIN after TIMEOUT RUN cycles) is built only when PROG_TIMEOUT_EN is defined.
module prog_launch_ctrl #(
    parameter int L       = 10,
    parameter int NPROG   = 3,
    parameter int ENTRY0  = 0,
    parameter int ENTRY1  = 190,
    parameter int ENTRY2  = 639,
    parameter int ENTRY3  = 0,
    parameter int TIMEOUT = 4096
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         DoneInstr,
    output logic         PCHold,
    output logic         PCLoad,
    output logic [L-1:0] PCLoadAddr,
    output logic [1:0]   ProgIdx,
    output logic         Running,
    output logic         Done,
    output logic         TimedOut
);

    typedef enum logic [2:0] {IDLE, ARMED, LOAD, RUN, FIN} state_t;

    localparam logic [2:0] NPROG_W = 3'(NPROG);

    state_t     state;
    logic       start_r;
    logic [2:0] prog_cnt;   // one bit wider than ProgIdx so NPROG=4 can saturate
    logic       rise, fall;
    logic       time_up;
    logic [2:0] prog_cnt_next;

    assign rise = Start & ~start_r;
    assign fall = ~Start & start_r;
    assign prog_cnt_next = (prog_cnt < NPROG_W) ? prog_cnt + 3'd1 : prog_cnt;
    assign ProgIdx = (prog_cnt > 3'd3) ? 2'd3 : prog_cnt[1:0];

    function automatic logic [L-1:0] entry_addr(input logic [2:0] idx);
        if (idx >= NPROG_W) return '0;
        case (idx)
            3'd0:    return L'(ENTRY0);
            3'd1:    return L'(ENTRY1);
            3'd2:    return L'(ENTRY2);
            3'd3:    return L'(ENTRY3);
            default: return '0;
        endcase
    endfunction

`ifdef PROG_TIMEOUT_EN
    localparam logic [15:0] RUN_LAST = 16'(TIMEOUT - 1);

    logic [15:0] run_cycles;

    assign time_up = (state == RUN) && (run_cycles == RUN_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_cycles <= '0;
            TimedOut   <= 1'b0;
        end else begin
            if (state == LOAD)
                run_cycles <= '0;
            else if (state == RUN)
                run_cycles <= run_cycles + 16'd1;
            if (state == IDLE && rise)
                TimedOut <= 1'b0;
            else if (time_up)
                TimedOut <= 1'b1;
        end
    end
`else
    assign time_up  = 1'b0;
    assign TimedOut = 1'b0;
`endif

    // NOTE: Reset is sampled on Clk only, so it sits inside the clocked branch, not the sensitivity list.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            start_r    <= 1'b0;
            prog_cnt   <= '0;
            Done       <= 1'b0;
            Running    <= 1'b0;
            PCHold     <= 1'b1;
            PCLoad     <= 1'b0;
            PCLoadAddr <= L'(ENTRY0);
        end else begin
            start_r <= Start;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= ARMED;
                        Done  <= 1'b0;
                    end
                end
                ARMED: begin
                    if (fall) begin
                        if (prog_cnt < NPROG_W) begin
                            state  <= LOAD;
                            PCLoad <= 1'b1;
                            PCHold <= 1'b0;
                        end else begin
                            state <= IDLE;
                            Done  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state   <= RUN;
                    PCLoad  <= 1'b0;
                    Running <= 1'b1;
                end
                RUN: begin
                    // a watchdog expiry is treated exactly like the done instruction
                    if (DoneInstr || time_up) begin
                        state   <= FIN;
                        Running <= 1'b0;
                        PCHold  <= 1'b1;
                    end
                end
                FIN: begin
                    state      <= IDLE;
                    Done       <= 1'b1;
                    prog_cnt   <= prog_cnt_next;
                    PCLoadAddr <= entry_addr(prog_cnt_next);
                end
                default: begin
                    state   <= IDLE;
                    PCHold  <= 1'b1;
                    PCLoad  <= 1'b0;
                    Running <= 1'b0;
                end
            endcase
        end
    end

endmodule
